mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw)
//  of the 5-stage MIPS pipeline. One outstanding access at a time; data port has priority; anti-starvation

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MIPS pipeline, the unified memory and mem_port_arbiter.
// slave  : arbiter view (takes IF/DM requests, drives memory strobe and responses)
// master : environment view (pipeline + memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rvalid, if_rdata, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rvalid, if_rdata, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data stage. One access in flight, data port has priority, a
// starvation counter forces fetch to win after STARVE_MAX consecutive losses.
// Optional build macro MEM_ARB_PERF_EN adds saturating perf counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_conflict,
  output logic [15:0]       perf_if_wait
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic              own_dm;
  logic              own_we;
  logic [SW-1:0]     starve_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              if_rvalid_r;
  logic              dm_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;
  logic              dm_win;
  logic              stall_if;

  // Data port wins a tie unless fetch has already lost STARVE_MAX in a row.
  assign dm_win = bus.dm_req && !(bus.if_req && starve_cnt == SW'(STARVE_MAX));

  assign stall_if      = bus.if_req & ~if_rvalid_r;
  assign bus.stall_if  = stall_if;
  assign bus.stall_mem = bus.dm_req & ~dm_rvalid_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.dm_rvalid = dm_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_rdata  = dm_rdata_r;

  // Access FSM; all outputs are registered and default to zero each cycle so
  // strobes and response pulses last exactly one cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state       <= S_IDLE;
      own_dm      <= 1'b0;
      own_we      <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
      case (state)
        S_IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            // The memory strobe registers double as the request latch.
            state    <= S_ISSUE;
            mem_en_r <= 1'b1;
            if (dm_win) begin
              own_dm      <= 1'b1;
              own_we      <= bus.dm_we;
              mem_we_r    <= bus.dm_we;
              mem_addr_r  <= bus.dm_addr;
              mem_wdata_r <= bus.dm_wdata;
              if (bus.if_req && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              own_dm      <= 1'b0;
              own_we      <= 1'b0;
              mem_addr_r  <= bus.if_addr;
              starve_cnt  <= '0;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= WW'(MEM_LAT - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            // Capture cycle: mem_rdata is valid MEM_LAT cycles after the strobe.
            state <= S_RESP;
            if (own_dm) begin
              dm_rvalid_r <= 1'b1;
              dm_rdata_r  <= own_we ? '0 : bus.mem_rdata;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= bus.mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating counters: IDLE-cycle conflicts and cycles fetch is stalled.
  always_ff @(posedge clk) begin
    if (RESET) begin
      perf_conflict <= '0;
      perf_if_wait  <= '0;
    end else begin
      if (state == S_IDLE && bus.if_req && bus.dm_req && perf_conflict != 16'hFFFF)
        perf_conflict <= perf_conflict + 16'd1;
      if (stall_if && perf_if_wait != 16'hFFFF)
        perf_if_wait <= perf_if_wait + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// every memory strobe and every response (cycle, port, data); a monitor on
// the falling edge pops and compares.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, L = 2, SM = 4;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_conflict, perf_if_wait;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .RESET(RESET),
    .bus(bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_if_wait(perf_if_wait)
`endif
  );

  typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; } macc_t;
  typedef struct { int cyc; bit dm; logic [31:0] data; } rsp_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  bit if_done = 1'b0, dm_done = 1'b0;
  bit if_busy = 1'b0, dm_busy = 1'b0;
  macc_t mq[$];
  rsp_t  rq[$];
  bit    order[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  logic [31:0] rd_at [int];
  int free_at = 0;
  int starve = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    return a;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  // Memory environment: answers loads exactly L cycles after the strobe and
  // drives noise otherwise, so a mistimed capture is visible.
  always @(negedge clk) begin
    if (rd_at.exists(cyc)) begin
      bus.mem_rdata = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      bus.mem_rdata = $urandom;
    end
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) env_mem[bus.mem_addr] = bus.mem_wdata;
      else rd_at[cyc + L] = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : dflt(bus.mem_addr);
    end
  end

  // Monitor first (compares this cycle), then the reference model (predicts
  // future cycles from the request inputs seen now).
  always @(negedge clk) begin : sb
    bit exp_me, exp_ir, exp_dr, dm_win;
    macc_t m;
    rsp_t r;
    int c;
    if (mon_on) begin
      c = cyc;
      exp_me = (mq.size() > 0) && (mq[0].cyc == c);
      chk("mem_en", 64'(bus.mem_en), 64'(exp_me));
      if (exp_me) begin
        m = mq.pop_front();
        chk("mem_we", 64'(bus.mem_we), 64'(m.we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
      end else begin
        chk("mem_idle_bus", {bus.mem_addr, bus.mem_wdata} | 64'(bus.mem_we), 64'd0);
      end
      exp_ir = (rq.size() > 0) && (rq[0].cyc == c) && !rq[0].dm;
      exp_dr = (rq.size() > 0) && (rq[0].cyc == c) && rq[0].dm;
      chk("if_rvalid", 64'(bus.if_rvalid), 64'(exp_ir));
      chk("dm_rvalid", 64'(bus.dm_rvalid), 64'(exp_dr));
      chk("if_rdata", 64'(bus.if_rdata), exp_ir ? 64'(rq[0].data) : 64'd0);
      chk("dm_rdata", 64'(bus.dm_rdata), exp_dr ? 64'(rq[0].data) : 64'd0);
      chk("stall_if", 64'(bus.stall_if), 64'(bus.if_req && !exp_ir));
      chk("stall_mem", 64'(bus.stall_mem), 64'(bus.dm_req && !exp_dr));
      if (exp_ir || exp_dr) r = rq.pop_front();
      if (bus.if_rvalid === 1'b1) begin if_done = 1'b1; order.push_back(1'b0); end
      if (bus.dm_rvalid === 1'b1) begin dm_done = 1'b1; order.push_back(1'b1); end

      if (RESET) begin
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].cyc > c) mq.delete(i);
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc > c) rq.delete(i);
        free_at = c + 1;
        starve = 0;
      end else if (c >= free_at && (bus.if_req || bus.dm_req)) begin
        dm_win = bus.dm_req && !(bus.if_req && starve == SM);
        if (!dm_win) starve = 0;
        else if (bus.if_req && starve < SM) starve++;
        if (dm_win) begin
          m.we = bus.dm_we; m.addr = bus.dm_addr; m.wdata = bus.dm_wdata;
        end else begin
          m.we = 1'b0; m.addr = bus.if_addr; m.wdata = '0;
        end
        m.cyc = c + 1;
        r.cyc = c + 2 + L;
        r.dm = dm_win;
        if (m.we) begin
          mdl_mem[m.addr] = m.wdata;
          r.data = '0;
        end else begin
          r.data = mdl_mem.exists(m.addr) ? mdl_mem[m.addr] : dflt(m.addr);
        end
        mq.push_back(m);
        rq.push_back(r);
        free_at = c + L + 3;
      end
    end
  end

  task automatic drop_all();
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    RESET = 1'b1;
    drop_all();
    @(posedge clk); #1;
    RESET = 1'b0;
    if_done = 0; dm_done = 0; if_busy = 0; dm_busy = 0;
    order.delete();
    mon_on = 1'b1;
  endtask

  task automatic wait_flag(input bit dm, input int maxc);
    for (int n = 0; n < maxc; n++) begin
      @(posedge clk); #1;
      if (dm && dm_done) begin dm_done = 0; return; end
      if (!dm && if_done) begin if_done = 0; return; end
    end
    checks++; errors++;
    $display("FAIL timeout waiting for %s rvalid cyc=%0d", dm ? "dm" : "if", cyc);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int t0;
    bit exp_order [6];
    drop_all();
    bus.mem_rdata = '0;
    do_reset();

    // Fetch alone: strobe at +1, response at +4 with the memory word.
    env_mem[32'h10] = 32'hDEADBEEF; mdl_mem[32'h10] = 32'hDEADBEEF;
    t0 = cyc;
    bus.if_req = 1; bus.if_addr = 32'h10;
    wait_flag(0, 20);
    chk("t1_latency", 64'(cyc - t0), 64'd5);
    drop_all();

    // Simultaneous requests: data load first, fetch next.
    do_reset();
    t0 = cyc;
    bus.if_req = 1; bus.if_addr = 32'h14;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    wait_flag(1, 20);
    chk("t2_dm_latency", 64'(cyc - t0), 64'd5);
    bus.dm_req = 0; bus.dm_addr = '0;
    wait_flag(0, 20);
    chk("t2_if_latency", 64'(cyc - t0), 64'd10);
    bus.if_req = 0; bus.if_addr = '0;
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict", 64'(perf_conflict), 64'd1);
    chk("perf_if_wait", 64'(perf_if_wait), 64'd9);
`endif

    // Starvation: data port never lets go; fetch must win the fifth access.
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h8;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h4;
    for (int n = 0; n < 80 && order.size() < 6; n++) begin
      @(posedge clk); #1;
      if (dm_done) begin dm_done = 0; bus.dm_addr = rand_addr(); end
      if (if_done) begin if_done = 0; bus.if_req = 0; end
    end
    drop_all();
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    chk("t3_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk($sformatf("t3_winner%0d", i), 64'(order[i]), 64'(exp_order[i]));
    repeat (8) @(posedge clk);

    // Store then load back the same word.
    #1;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h55;
    wait_flag(1, 20);
    bus.dm_we = 0; bus.dm_wdata = '0;
    wait_flag(1, 20);
    drop_all();

    // Reset during WAIT: the in-flight load must never respond.
    repeat (3) @(posedge clk);
    #1;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h30;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1; drop_all();
    @(posedge clk); #1;
    RESET = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_rvalid", 64'(dm_done), 64'd0);
    bus.if_req = 1; bus.if_addr = 32'h30;
    wait_flag(0, 20);
    drop_all();

    // Random traffic on both ports.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (if_done) begin if_done = 0; if_busy = 0; end
      if (dm_done) begin dm_done = 0; dm_busy = 0; end
      if (!if_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          if_busy = 1; bus.if_req = 1; bus.if_addr = rand_addr();
        end else begin
          bus.if_req = 0;
        end
      end
      if (!dm_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_busy = 1; bus.dm_req = 1; bus.dm_we = 1'($urandom_range(0, 1));
          bus.dm_addr = rand_addr(); bus.dm_wdata = $urandom;
        end else begin
          bus.dm_req = 0; bus.dm_we = 0;
        end
      end
    end
    for (int k = 0; k < 60 && (if_busy || dm_busy); k++) begin
      @(posedge clk); #1;
      if (if_done) begin if_done = 0; if_busy = 0; bus.if_req = 0; end
      if (dm_done) begin dm_done = 0; dm_busy = 0; bus.dm_req = 0; end
    end
    drop_all();
    repeat (10) @(posedge clk);
    #1;
    chk("drain_mem_q", 64'(mq.size()), 64'd0);
    chk("drain_rsp_q", 64'(rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
